// File: rtl/pixel_packet_writer_pkg.sv
// Shared constants, state encoding and helpers for pixel_packet_writer.
package pixel_packet_writer_pkg;

  localparam int unsigned PACKET_BUFFER_SIZE = 16384;
  localparam int unsigned COLOR_LEN          = 12;
  localparam int unsigned STAT_W             = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  typedef enum logic [2:0] {
    PPW_ST_HDR_HI,
    PPW_ST_HDR_LO,
    PPW_ST_B0,
    PPW_ST_B1,
    PPW_ST_B2
  } ppw_state_e;

endpackage

// File: rtl/pixel_packet_writer_sat_counter.sv
// Saturating event counter; holds at all-ones once full.
module pixel_packet_writer_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pixel_packet_writer.sv
// Unpacks header + 12-bit packed pixel byte stream into video cache RAM writes.
// Optional packet/drop statistics under PIXEL_PACKET_WRITER_STATS_EN.
module pixel_packet_writer
  import pixel_packet_writer_pkg::*;
#(
  parameter int unsigned RAM_SIZE = PACKET_BUFFER_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inclk,
  input  logic [7:0]                 in,
  input  logic                       in_done,
  output logic                       ram_writeclk,
  output logic [clog2(RAM_SIZE)-1:0] ram_waddr,
  output logic [COLOR_LEN-1:0]       ram_win,
`ifdef PIXEL_PACKET_WRITER_STATS_EN
  output logic [STAT_W-1:0]          pkt_count,
  output logic [STAT_W-1:0]          drop_count,
`endif
  output logic                       frame_done
);

  localparam int unsigned ADDR_W = clog2(RAM_SIZE);

  ppw_state_e state, state_next, state_adv;

  logic [7:0]           hdr_hi;
  logic [ADDR_W-1:0]    base;
  logic [ADDR_W-1:0]    pix_idx;
  logic [7:0]           b0;
  logic [3:0]           nib;

  logic                 wr_en;
  logic [COLOR_LEN-1:0] wr_data;
  logic [ADDR_W-1:0]    wr_addr;

  assign wr_addr = base + pix_idx;

  // state_adv is where the byte alone would lead; in_done then overrides to the header.
  always_comb begin
    state_adv = state;
    wr_en     = 1'b0;
    wr_data   = '0;
    if (inclk) begin
      unique case (state)
        PPW_ST_HDR_HI: state_adv = PPW_ST_HDR_LO;
        PPW_ST_HDR_LO: state_adv = PPW_ST_B0;
        PPW_ST_B0:     state_adv = PPW_ST_B1;
        PPW_ST_B1: begin
          state_adv = PPW_ST_B2;
          wr_en     = 1'b1;
          wr_data   = {b0, in[7:4]};
        end
        PPW_ST_B2: begin
          state_adv = PPW_ST_B0;
          wr_en     = 1'b1;
          wr_data   = {nib, in};
        end
        default:       state_adv = PPW_ST_HDR_HI;
      endcase
    end
    state_next = in_done ? PPW_ST_HDR_HI : state_adv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PPW_ST_HDR_HI;
      hdr_hi       <= '0;
      base         <= '0;
      pix_idx      <= '0;
      b0           <= '0;
      nib          <= '0;
      ram_writeclk <= 1'b0;
      ram_waddr    <= '0;
      ram_win      <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_next;
      ram_writeclk <= wr_en;
      frame_done   <= wr_en && (wr_addr == '1);
      if (wr_en) begin
        ram_waddr <= wr_addr;
        ram_win   <= wr_data;
        pix_idx   <= pix_idx + ADDR_W'(1);
      end
      if (inclk) begin
        unique case (state)
          PPW_ST_HDR_HI: hdr_hi <= in;
          PPW_ST_HDR_LO: begin
            base    <= ADDR_W'({hdr_hi, in});
            pix_idx <= '0;
          end
          PPW_ST_B0:     b0  <= in;
          PPW_ST_B1:     nib <= in[3:0];
          default:       ;
        endcase
      end
    end
  end

`ifdef PIXEL_PACKET_WRITER_STATS_EN
  logic drop;

  // A packet is incomplete if it finishes with only part of a header or pixel group held.
  assign drop = in_done && ((state_adv == PPW_ST_HDR_LO) ||
                            (state_adv == PPW_ST_B1) ||
                            (state_adv == PPW_ST_B2));

  pixel_packet_writer_sat_counter #(.W(STAT_W)) u_pkt_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (in_done),
    .count (pkt_count)
  );

  pixel_packet_writer_sat_counter #(.W(STAT_W)) u_drop_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .count (drop_count)
  );
`endif

endmodule

// File: tb/tb_pixel_packet_writer.sv
// Directed table-driven bench for pixel_packet_writer (RAM_SIZE = 16384).
module tb_pixel_packet_writer;

  logic        clk;
  logic        rst;
  logic        inclk;
  logic [7:0]  in;
  logic        in_done;
  logic        ram_writeclk;
  logic [13:0] ram_waddr;
  logic [11:0] ram_win;
  logic        frame_done;
`ifdef PIXEL_PACKET_WRITER_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        ink;
    bit [7:0]  d;
    bit        dn;
    bit        we;
    bit [13:0] a;
    bit [11:0] wd;
    bit        fd;
  } vec_t;

  vec_t vecs[$];

  pixel_packet_writer #(.RAM_SIZE(16384)) dut (
    .clk          (clk),
    .rst          (rst),
    .inclk        (inclk),
    .in           (in),
    .in_done      (in_done),
    .ram_writeclk (ram_writeclk),
    .ram_waddr    (ram_waddr),
    .ram_win      (ram_win),
`ifdef PIXEL_PACKET_WRITER_STATS_EN
    .pkt_count    (pkt_count),
    .drop_count   (drop_count),
`endif
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input bit ink, input bit [7:0] d, input bit dn,
                     input bit we, input bit [13:0] a, input bit [11:0] wd, input bit fd);
    vec_t v;
    v.ink = ink; v.d = d; v.dn = dn; v.we = we; v.a = a; v.wd = wd; v.fd = fd;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(0, 8'h00, 0, 0, 14'h0, 12'h0, 0);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      bit ok;
      inclk   = vecs[i].ink;
      in      = vecs[i].d;
      in_done = vecs[i].dn;
      @(posedge clk);
      #1;
      if (vecs[i].we)
        ok = (ram_writeclk === 1'b1) && (ram_waddr === vecs[i].a) &&
             (ram_win === vecs[i].wd) && (frame_done === vecs[i].fd);
      else
        ok = (ram_writeclk === 1'b0) && (frame_done === 1'b0);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s row %0d: got we=%b addr=%h data=%h fd=%b, want we=%b addr=%h data=%h fd=%b",
                 tag, i, ram_writeclk, ram_waddr, ram_win, frame_done,
                 vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].fd);
      end
    end
    inclk = 0; in = 8'h00; in_done = 0;
    vecs.delete();
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  initial begin
    rst = 1; inclk = 0; in = 8'h00; in_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outputs", {17'b0, ram_writeclk, ram_waddr, ram_win, frame_done}, 32'h0);
    @(negedge clk);
    rst = 0;

    // back-to-back strobes
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h10, 0, 0, 0, 0, 0);
    add(1, 8'hAB, 0, 0, 0, 0, 0);
    add(1, 8'hCD, 0, 1, 14'h0010, 12'hABC, 0);
    add(1, 8'hEF, 1, 1, 14'h0011, 12'hDEF, 0);
    idle(1);
    // last address then wrap
    add(1, 8'h3F, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'h12, 0, 0, 0, 0, 0);
    add(1, 8'h34, 0, 1, 14'h3FFF, 12'h123, 1);
    add(1, 8'h56, 1, 1, 14'h0000, 12'h456, 0);
    idle(1);
    // trailing nibble dropped
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h11, 0, 0, 0, 0, 0);
    add(1, 8'h22, 1, 1, 14'h0000, 12'h112, 0);
    idle(1);
    // abort with b0 held
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h05, 0, 0, 0, 0, 0);
    add(1, 8'h77, 0, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0);
    idle(1);
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'hA1, 0, 0, 0, 0, 0);
    add(1, 8'hB2, 0, 1, 14'h0000, 12'hA1B, 0);
    add(1, 8'hC3, 1, 1, 14'h0001, 12'h2C3, 0);
    idle(1);
    // spaced strobes, 3 idle cycles apart
    add(1, 8'h00, 0, 0, 0, 0, 0); idle(3);
    add(1, 8'h10, 0, 0, 0, 0, 0); idle(3);
    add(1, 8'hAB, 0, 0, 0, 0, 0); idle(3);
    add(1, 8'hCD, 0, 1, 14'h0010, 12'hABC, 0); idle(3);
    add(1, 8'hEF, 1, 1, 14'h0011, 12'hDEF, 0); idle(3);
    run_vecs("stream");

`ifdef PIXEL_PACKET_WRITER_STATS_EN
    check_val("pkt_count_phase1", {16'h0, pkt_count}, 32'd6);
    check_val("drop_count_phase1", {16'h0, drop_count}, 32'd2);
`endif

    // reset between bytes 2 and 3 of a group, right after a pixel write
    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h07, 0, 0, 0, 0, 0);
    add(1, 8'h11, 0, 0, 0, 0, 0);
    add(1, 8'h22, 0, 1, 14'h0007, 12'h112, 0);
    run_vecs("pre_reset");
    #2 rst = 1;
    #1;
    check_val("async_reset_outputs", {17'b0, ram_writeclk, ram_waddr, ram_win, frame_done}, 32'h0);
`ifdef PIXEL_PACKET_WRITER_STATS_EN
    check_val("async_reset_pkt", {16'h0, pkt_count}, 32'd0);
`endif
    @(negedge clk);
    rst = 0;

    add(1, 8'h00, 0, 0, 0, 0, 0);
    add(1, 8'h02, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0);
    add(1, 8'hFF, 0, 1, 14'h0002, 12'hFFF, 0);
    add(1, 8'hFF, 1, 1, 14'h0003, 12'hFFF, 0);
    idle(2);
    run_vecs("post_reset");

`ifdef PIXEL_PACKET_WRITER_STATS_EN
    check_val("pkt_count_phase2", {16'h0, pkt_count}, 32'd1);
    check_val("drop_count_phase2", {16'h0, drop_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
